// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus types for the core-to-cache arbiter: ibus/dbus request and
// response structs, the merged cbus request/response, and size/len/burst
// encodings. Ports: none (package).
package mem_bus_arbiter_pkg;

    typedef logic [2:0] msize_t;
    localparam msize_t MSIZE4 = 3'b010;
    localparam msize_t MSIZE8 = 3'b011;

    // AXI-style length encoding: beats minus one.
    typedef logic [3:0] mlen_t;
    localparam mlen_t MLEN1 = 4'd0;

    typedef logic [1:0] axi_burst_t;
    localparam axi_burst_t AXI_BURST_FIXED = 2'b00;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating ibus starvation counter: counts dbus wins while ibus waits.
// Latency: at_max_o reflects the registered count (one cycle after inc_i).
// Backpressure: none; clr_i takes priority over inc_i.
// Ports: clk, reset (sync, active-low), inc_i, clr_i, at_max_o.
module arb_starve_ctr #(
    parameter int MAX = 4,
    parameter int W   = 3   // 2**W must exceed MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Merges core ibus and dbus into one single-beat cbus; dbus-first with ibus anti-starvation.
// Latency: request seen in IDLE cycle N drives oreq.valid from N+1; response combinational on ready&&last.
// Backpressure: request held on cbus until ready&&last; one IDLE cycle between transactions.
// Ports: clk, reset (sync, active-low), ireq/iresp (ibus), dreq/dresp (dbus),
//        oreq/oresp (cache/memory bus). Struct layouts live in mem_bus_arbiter_pkg.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [$bits(ibus_req_t)-1:0]    ireq,
    output logic [$bits(ibus_resp_t)-1:0]   iresp,
    input  logic [$bits(dbus_req_t)-1:0]    dreq,
    output logic [$bits(dbus_resp_t)-1:0]   dresp,
    output logic [$bits(cbus_req_t)-1:0]    oreq,
    input  logic [$bits(cbus_resp_t)-1:0]   oresp
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;

    ibus_req_t  ireq_s;
    dbus_req_t  dreq_s;
    cbus_resp_t oresp_s;
    ibus_resp_t iresp_s;
    dbus_resp_t dresp_s;

    assign ireq_s  = ireq;
    assign dreq_s  = dreq;
    assign oresp_s = oresp;

    arb_state_t state_q, state_d;
    cbus_req_t  lat_q, lat_d;    // valid bit doubles as "BUSY" for the cbus
    logic       grant_d, grant_i, done, at_max;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        grant_d = 1'b0;
        grant_i = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (dreq_s.valid && !(ireq_s.valid && at_max)) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                    lat_d   = '{valid: 1'b1, is_write: |dreq_s.strobe, size: dreq_s.size,
                                addr: dreq_s.addr, strobe: dreq_s.strobe, data: dreq_s.data,
                                len: MLEN1, burst: AXI_BURST_FIXED};
                end else if (ireq_s.valid) begin
                    grant_i = 1'b1;
                    state_d = BUSY_I;
                    lat_d   = '{valid: 1'b1, is_write: 1'b0, size: MSIZE4,
                                addr: ireq_s.addr, strobe: 8'h00, data: 64'h0,
                                len: MLEN1, burst: AXI_BURST_FIXED};
                end
            end
            BUSY_I, BUSY_D: begin
                // ready without last never completes; only single beats are issued.
                if (oresp_s.ready && oresp_s.last) begin
                    done        = 1'b1;
                    state_d     = IDLE;
                    lat_d.valid = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Only the winner sees a response, and only if it is still requesting;
    // a completion landing while reset is held is dropped.
    always_comb begin
        iresp_s = '0;
        dresp_s = '0;
        if (done && reset) begin
            if (state_q == BUSY_I && ireq_s.valid) begin
                iresp_s.addr_ok = 1'b1;
                iresp_s.data_ok = 1'b1;
                iresp_s.data    = lat_q.addr[2] ? oresp_s.data[63:32] : oresp_s.data[31:0];
            end
            if (state_q == BUSY_D && dreq_s.valid) begin
                dresp_s.addr_ok = 1'b1;
                dresp_s.data_ok = 1'b1;
                dresp_s.data    = oresp_s.data;
            end
        end
    end

    assign iresp = iresp_s;
    assign dresp = dresp_s;
    assign oreq  = lat_q;

    arb_starve_ctr #(
        .MAX (STARVE_MAX),
        .W   (CNT_W)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc_i    (grant_d && ireq_s.valid),
        .clr_i    (grant_i || (state_q == IDLE && !ireq_s.valid)),
        .at_max_o (at_max)
    );

endmodule
